// File: rtl/qpimem_dma_pixfeed_pkg.sv
// Shared types and sizing helpers for the QPI DMA pixel feeder.
package qpimem_dma_pixfeed_pkg;

  typedef enum logic [1:0] {
    BPP4  = 2'd0,
    BPP8  = 2'd1,
    BPP16 = 2'd2
  } bpp_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Code 3 is an alias of 16bpp.
  function automatic bpp_e decode_bpp(input logic [1:0] code);
    case (code)
      2'd0:    return BPP4;
      2'd1:    return BPP8;
      default: return BPP16;
    endcase
  endfunction

  // Index of the last pixel in a 32-bit word (pixels per word minus one).
  function automatic logic [2:0] last_index(input bpp_e mode);
    case (mode)
      BPP4:    return 3'd7;
      BPP8:    return 3'd3;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] frame_bytes(input int unsigned h, input int unsigned v, input bpp_e mode);
    case (mode)
      BPP4:    return 32'((h * v) / 2);
      BPP8:    return 32'(h * v);
      default: return 32'(h * v * 2);
    endcase
  endfunction

endpackage

// File: rtl/qpimem_dma_pixfeed_unpack.sv
// Combinational pixel selector: picks pixel 'index' out of a little-endian packed word.
module qpimem_dma_pixfeed_unpack
  import qpimem_dma_pixfeed_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  index,
  input  bpp_e        mode,
  output logic [15:0] pixel
);

  // Select and zero-extend the addressed pixel.
  always_comb begin
    pixel = 16'd0;
    case (mode)
      BPP4:    pixel = {12'd0, word[{index, 2'b00} +: 4]};
      BPP8:    pixel = {8'd0, word[{index[1:0], 3'b000} +: 8]};
      default: pixel = word[{index[0], 4'b0000} +: 16];
    endcase
  end

endmodule

// File: rtl/qpimem_dma_pixfeed.sv
// Frame sequencer: arms the QPI DMA reader with a framebuffer window and unpacks its words into a pixel stream.
module qpimem_dma_pixfeed
  import qpimem_dma_pixfeed_pkg::*;
#(
  parameter int H_RES      = 480,
  parameter int V_RES      = 320,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic [1:0]            bpp_mode,
  output logic                  dma_run,
  output logic [ADDR_WIDTH-1:0] dma_addr_start,
  output logic [ADDR_WIDTH-1:0] dma_addr_end,
  input  logic                  dma_ready,
  input  logic                  dma_all_done,
  output logic                  dma_do_read,
  input  logic [31:0]           dma_rdata,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [15:0]           pix_data,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic                  underrun
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  state_e                  state_r, state_n_s;
  bpp_e                    mode_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [31:0]             word_r, word_n_s;
  logic [2:0]              idx_r, idx_n_s;
  logic                    valid_n_s;
  logic [XW-1:0]           x_r, x_n_s;
  logic [YW-1:0]           y_r, y_n_s;
  logic [31:0]             words_r, words_total_r;
  logic                    fire_s, last_s, load_s;
  logic [15:0]             pixel_n_s;
  logic                    unused_status_s;

  assign unused_status_s = dma_all_done;
  assign dma_do_read     = load_s;

  qpimem_dma_pixfeed_unpack u_unpack (
    .word  (word_n_s),
    .index (idx_n_s),
    .mode  (mode_r),
    .pixel (pixel_n_s)
  );

  // Next-state, word-load and pixel/counter advance decisions.
  always_comb begin
    fire_s    = pix_valid && pix_ready;
    last_s    = (idx_r == last_index(mode_r));
    load_s    = 1'b0;
    state_n_s = state_r;
    word_n_s  = word_r;
    idx_n_s   = idx_r;
    valid_n_s = pix_valid;
    x_n_s     = x_r;
    y_n_s     = y_r;

    // A restart or disable this cycle must not consume a word that would be discarded.
    if ((state_r == STREAM) && enable && !frame_start && dma_ready &&
        (words_r != words_total_r) && (!pix_valid || (fire_s && last_s))) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end

    if (load_s) begin
      word_n_s  = dma_rdata;
      idx_n_s   = 3'd0;
      valid_n_s = 1'b1;
    end else if (fire_s && last_s) begin
      idx_n_s   = 3'd0;
      valid_n_s = 1'b0;
    end else if (fire_s) begin
      idx_n_s   = idx_r + 3'd1;
    end else begin
      idx_n_s   = idx_r;
    end

    if (fire_s) begin
      if (x_r == X_LAST) begin
        x_n_s = {XW{1'b0}};
        if (y_r == Y_LAST) begin
          y_n_s = {YW{1'b0}};
        end else begin
          y_n_s = y_r + YW'(1);
        end
      end else begin
        x_n_s = x_r + XW'(1);
      end
    end else begin
      x_n_s = x_r;
    end

    case (state_r)
      IDLE: begin
        if (frame_start) state_n_s = ARM;
        else             state_n_s = IDLE;
      end
      ARM:  state_n_s = STREAM;
      STREAM: begin
        if (frame_start)             state_n_s = ARM;
        else if (fire_s && pix_eof)  state_n_s = DONE;
        else                         state_n_s = STREAM;
      end
      DONE: begin
        if (frame_start) state_n_s = ARM;
        else             state_n_s = DONE;
      end
      default: state_n_s = IDLE;
    endcase

    if (!enable) begin
      state_n_s = IDLE;
    end else begin
      state_n_s = state_n_s;
    end

    // Leaving STREAM (end, abort or disable) drops the holding word and position.
    if (state_n_s != STREAM) begin
      word_n_s  = 32'd0;
      idx_n_s   = 3'd0;
      valid_n_s = 1'b0;
      x_n_s     = {XW{1'b0}};
      y_n_s     = {YW{1'b0}};
    end else begin
      valid_n_s = valid_n_s;
    end
  end

  // State, window, holding register and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      mode_r         <= BPP4;
      base_r         <= {ADDR_WIDTH{1'b0}};
      word_r         <= 32'd0;
      idx_r          <= 3'd0;
      x_r            <= {XW{1'b0}};
      y_r            <= {YW{1'b0}};
      words_r        <= 32'd0;
      words_total_r  <= 32'd0;
      dma_run        <= 1'b0;
      dma_addr_start <= {ADDR_WIDTH{1'b0}};
      dma_addr_end   <= {ADDR_WIDTH{1'b0}};
      pix_valid      <= 1'b0;
      pix_data       <= 16'd0;
      pix_eol        <= 1'b0;
      pix_eof        <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      dma_run   <= (state_n_s == STREAM) || (state_n_s == DONE);
      word_r    <= word_n_s;
      idx_r     <= idx_n_s;
      x_r       <= x_n_s;
      y_r       <= y_n_s;
      pix_valid <= valid_n_s;
      pix_data  <= valid_n_s ? pixel_n_s : 16'd0;
      pix_eol   <= valid_n_s && (x_n_s == X_LAST);
      pix_eof   <= valid_n_s && (x_n_s == X_LAST) && (y_n_s == Y_LAST);
      underrun  <= (state_r == STREAM) && pix_ready && !pix_valid;

      if (state_n_s == ARM) begin
        base_r <= fb_addr & ~ADDR_WIDTH'(3);
        mode_r <= decode_bpp(bpp_mode);
      end

      if (state_r == ARM) begin
        words_r        <= 32'd0;
        words_total_r  <= frame_bytes(H_RES, V_RES, mode_r) >> 2;
        dma_addr_start <= base_r;
        dma_addr_end   <= base_r + ADDR_WIDTH'(frame_bytes(H_RES, V_RES, mode_r));
      end else if (load_s) begin
        words_r <= words_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_qpimem_dma_pixfeed.sv
// Randomized bench for qpimem_dma_pixfeed against a word-list pixel model and a simple reader model.
module tb_qpimem_dma_pixfeed;

  localparam int H = 8;
  localparam int V = 2;

  logic        clk = 1'b0;
  logic        rst, enable, frame_start, pix_ready;
  logic [23:0] fb_addr;
  logic [1:0]  bpp_mode;
  logic        dma_run, dma_ready, dma_all_done, dma_do_read;
  logic [23:0] dma_addr_start, dma_addr_end;
  logic [31:0] dma_rdata;
  logic        pix_valid, pix_eol, pix_eof, underrun;
  logic [15:0] pix_data;

  always #5 clk = ~clk;

  qpimem_dma_pixfeed #(.H_RES(H), .V_RES(V), .ADDR_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .fb_addr(fb_addr), .bpp_mode(bpp_mode), .dma_run(dma_run),
    .dma_addr_start(dma_addr_start), .dma_addr_end(dma_addr_end),
    .dma_ready(dma_ready), .dma_all_done(dma_all_done), .dma_do_read(dma_do_read),
    .dma_rdata(dma_rdata), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_eol(pix_eol), .pix_eof(pix_eof), .underrun(underrun)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reader model: a word list, restarted whenever run is low.
  logic [31:0] mem [8];
  int  rd_idx = 0;
  int  nwords = 0;
  bit  rdy_drive = 1'b0;
  int  cyc = 0;

  assign dma_ready    = rdy_drive && dma_run && (rd_idx < nwords);
  assign dma_rdata    = mem[rd_idx % 8];
  assign dma_all_done = dma_run && (rd_idx >= nwords);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!dma_run) rd_idx <= 0;
    else if (dma_do_read && dma_ready) rd_idx <= rd_idx + 1;
  end

  // Scoreboard state.
  int  exp_pix [16];
  int  npix = H * V;
  int  exp_idx = 0, first_cyc = 0, last_cyc = 0, s_cyc = 0, urun_cnt = 0;
  bit  mon_on = 1'b0, stall_hold = 1'b0;
  logic [17:0] held;

  always @(negedge clk) begin
    if (mon_on) begin
      if (dma_do_read) check_eq("do_read_without_ready", dma_ready, 1'b1);
      if (stall_hold) begin
        check_eq("stall_valid", pix_valid, 1'b1);
        check_eq("stall_stable", {pix_data, pix_eol, pix_eof}, held);
      end
      if (pix_valid && pix_ready) begin
        if (exp_idx < npix) begin
          check_eq("pix_data", pix_data, exp_pix[exp_idx]);
          check_eq("pix_eol", pix_eol, (exp_idx % H) == H - 1);
          check_eq("pix_eof", pix_eof, exp_idx == npix - 1);
        end else begin
          check_eq("extra_pixel", exp_idx, npix - 1);
        end
        if (exp_idx == 0) first_cyc = cyc;
        last_cyc = cyc;
        exp_idx++;
      end
      stall_hold = pix_valid && !pix_ready;
      held = {pix_data, pix_eol, pix_eof};
      if (underrun && (cyc - s_cyc >= 3)) urun_cnt++;
    end
  end

  task automatic run_frame(input logic [1:0] mode, input logic [23:0] addr, input int rdy_pct,
                           input int prdy_pct, input int stall_at, input int abort_after, input bit fill);
    int bits, ppw, n, off;
    bit aborted;
    logic [23:0] exp_start, exp_end;
    bits = (mode == 2'd0) ? 4 : (mode == 2'd1) ? 8 : 16;
    ppw = 32 / bits;
    nwords = npix * bits / 32;
    if (fill) for (int i = 0; i < nwords; i++) mem[i] = $urandom;
    for (int k = 0; k < npix; k++)
      exp_pix[k] = int'((mem[k / ppw] >> ((k % ppw) * bits)) & ((32'd1 << bits) - 32'd1));
    exp_idx = 0; urun_cnt = 0;
    exp_start = addr & 24'hFFFFFC;
    exp_end = exp_start + 24'(npix * bits / 8);

    @(posedge clk); #1;
    frame_start = 1'b1; fb_addr = addr; bpp_mode = mode; pix_ready = 1'b0; rdy_drive = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b0; fb_addr = 24'($urandom); bpp_mode = 2'($urandom_range(3));
    @(negedge clk);
    check_eq("arm_run_low", dma_run, 1'b0);
    @(posedge clk); #1;
    s_cyc = cyc;
    check_eq("run_high", dma_run, 1'b1);
    check_eq("addr_start", dma_addr_start, exp_start);
    check_eq("addr_end", dma_addr_end, exp_end);

    aborted = 1'b0; n = 0;
    while (exp_idx < npix && n < 400) begin
      off = cyc - s_cyc;
      pix_ready = ($urandom_range(99) < prdy_pct);
      rdy_drive = ($urandom_range(99) < rdy_pct) &&
                  !(stall_at >= 0 && off >= stall_at && off <= stall_at + 4);
      if (abort_after >= 0 && !aborted && exp_idx == abort_after) begin
        frame_start = 1'b1; fb_addr = addr; bpp_mode = mode; aborted = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0; exp_idx = 0;
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    if (exp_idx < npix) check_eq("frame_timeout", exp_idx, npix);
    pix_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("done_valid_low", pix_valid, 1'b0);
    check_eq("done_run_high", dma_run, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; frame_start = 1'b0; fb_addr = 24'd0; bpp_mode = 2'd0; pix_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", {dma_run, dma_do_read, pix_valid, pix_eol, pix_eof, underrun, pix_data}, 64'd0);
    check_eq("reset_addrs", {dma_addr_start, dma_addr_end}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_outputs", {dma_run, dma_do_read, pix_valid, pix_eol, pix_eof, underrun, pix_data}, 64'd0);
    end
    mon_on = 1'b1;

    // 8bpp, full throughput, unaligned base.
    run_frame(2'd1, 24'h001003, 100, 100, -1, -1, 1'b1);
    check_eq("t2_start", dma_addr_start, 24'h001000);
    check_eq("t2_end", dma_addr_end, 24'h001010);
    check_eq("t2_consecutive", last_cyc - first_cyc, 15);

    // Directed pixel ordering at 4bpp and 16bpp.
    mem[0] = 32'h76543210;
    mem[1] = $urandom;
    run_frame(2'd0, 24'h000200, 100, 100, -1, -1, 1'b0);
    mem[0] = 32'hBEEFCAFE;
    for (int i = 1; i < 8; i++) mem[i] = $urandom;
    run_frame(2'd2, 24'h000300, 100, 100, -1, -1, 1'b0);

    // Random backpressure on both sides.
    for (int f = 0; f < 4; f++)
      run_frame(2'($urandom_range(3)), 24'($urandom), 60, 50, -1, -1, 1'b1);

    // Reader stalled for 5 cycles right at a word boundary.
    run_frame(2'd1, 24'h000400, 100, 100, 4, -1, 1'b1);
    check_eq("underrun_pulses", urun_cnt, 5);

    // Abort after pixel 5 with a wrapping window.
    run_frame(2'd2, 24'hFFFFF8, 100, 100, -1, 6, 1'b1);
    check_eq("abort_start", dma_addr_start, 24'hFFFFF8);
    check_eq("abort_end", dma_addr_end, 24'h000018);

    // Enable low mid-stream forces IDLE.
    exp_idx = 0;
    @(posedge clk); #1;
    frame_start = 1'b1; fb_addr = 24'hFFFFF8; bpp_mode = 2'd2; pix_ready = 1'b1; rdy_drive = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (5) @(posedge clk);
    #1; enable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("disable_valid", pix_valid, 1'b0);
    check_eq("disable_run", dma_run, 1'b0);
    enable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("reenable_idle_run", dma_run, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
